// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and command-master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// One-outstanding command-to-AXI4-Lite master with registered AXI and response outputs.
// Optional watchdog enabled by defining AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [1:0]              o_rsp_resp,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic                    o_busy,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    input  logic [1:0]              i_bresp,
    output logic                    o_bready,
    output logic                    o_arvalid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_arready,
    input  logic                    i_rvalid,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    o_rready
);

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || STROBE_WIDTH != DATA_WIDTH / 8
        || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("axi_lite_cmd_master: unsupported parameterisation");
    end

    state_e                  state_q;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STROBE_WIDTH-1:0] wstrb_q;
    logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                    rsp_valid_q;
    logic [1:0]              rsp_resp_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic tmo_hit_c;

    assign aw_hs_c = awvalid_q & i_awready;
    assign w_hs_c  = wvalid_q  & i_wready;
    assign b_hs_c  = bready_q  & i_bvalid;
    assign ar_hs_c = arvalid_q & i_arready;
    assign r_hs_c  = rready_q  & i_rvalid;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q;
    logic             waiting_c;
    logic             any_hs_c;

    assign waiting_c = (state_q == WR_REQ) || (state_q == WR_RSP) ||
                       (state_q == RD_REQ) || (state_q == RD_RSP);
    assign any_hs_c  = aw_hs_c | w_hs_c | b_hs_c | ar_hs_c | r_hs_c;
    assign tmo_hit_c = waiting_c && !any_hs_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts idle waiting cycles, restarted by any handshake
    always_ff @(posedge clk) begin
        if (rst || !waiting_c || any_hs_c) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_data_q  <= '0;
        end else if (tmo_hit_c) begin
            // Abandon the stalled transaction and report DECERR
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= RESP_DECERR;
            rsp_data_q  <= '0;
            state_q     <= DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        addr_q  <= i_cmd_addr;
                        wdata_q <= i_cmd_data;
                        wstrb_q <= i_cmd_strb;
                        busy_q  <= 1'b1;
                        if (i_cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs_c) awvalid_q <= 1'b0;
                    if (w_hs_c)  wvalid_q  <= 1'b0;
                    // Both channels finished, either earlier or on this edge
                    if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (b_hs_c) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= i_bresp;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                RD_REQ: begin
                    if (ar_hs_c) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (r_hs_c) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= i_rresp;
                        rsp_data_q  <= i_rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready = (state_q == IDLE);
    assign o_busy      = busy_q;
    assign o_awvalid   = awvalid_q;
    assign o_awaddr    = addr_q;
    assign o_wvalid    = wvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_bready    = bready_q;
    assign o_arvalid   = arvalid_q;
    assign o_araddr    = addr_q;
    assign o_rready    = rready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized bench for axi_lite_cmd_master: reactive register-slave model plus a reference memory.
module tb_axi_lite_cmd_master;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam logic [DW-1:0] VERSION = 32'h1000_0000;

    logic          clk, rst;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_strb;
    logic          o_rsp_valid, i_rsp_ready;
    logic [1:0]    o_rsp_resp;
    logic [DW-1:0] o_rsp_data;
    logic          o_busy;
    logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
    logic [AW-1:0] o_awaddr, o_araddr;
    logic [DW-1:0] o_wdata, i_rdata;
    logic [SW-1:0] o_wstrb;
    logic [1:0]    i_bresp, i_rresp;
    logic          o_arvalid, i_arready, i_rvalid, o_rready;

    axi_lite_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_resp(o_rsp_resp),
        .o_rsp_data(o_rsp_data), .o_busy(o_busy),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rresp(i_rresp), .i_rdata(i_rdata), .o_rready(o_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Slave knobs (set by the sequencer) and slave observations
    int            aw_dly = 0, w_dly = 0, ar_dly = 0, rsp_dly = 1;
    int            aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    logic [AW-1:0] slv_awaddr;
    logic [DW-1:0] slv_wdata;
    logic [SW-1:0] slv_wstrb;
    logic [DW-1:0] slv_mem [16];
    logic [DW-1:0] ref_mem [16];

    // Register slave: 16 words, word 1 is a read-only version register, >=0x40 is SLVERR
    initial begin : slave
        logic          aw_have, w_have, b_arm, r_arm;
        logic          aw_hold, w_hold, ar_hold;
        int            aw_wait, w_wait, ar_wait, b_tmr, r_tmr;
        logic [AW-1:0] hold_awaddr, hold_araddr, rd_addr;
        logic [SW+DW-1:0] hold_w;
        logic [1:0]    bresp_n;
        logic [DW-1:0] m;
        aw_have = 0; w_have = 0; b_arm = 0; r_arm = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_tmr = 0; r_tmr = 0;
        hold_awaddr = '0; hold_araddr = '0; rd_addr = '0; hold_w = '0; bresp_n = RESP_OKAY;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = '0;
        i_arready = 0; i_rvalid = 0; i_rresp = '0; i_rdata = '0;
        for (int i = 0; i < 16; i++) slv_mem[i] = (i == 1) ? VERSION : '0;
        forever begin
            @(posedge clk);
            aw_hold = 0; w_hold = 0; ar_hold = 0;
            if (rst) begin
                aw_have = 0; w_have = 0; b_arm = 0; r_arm = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (o_awvalid && i_awready) begin
                    slv_awaddr = o_awaddr; aw_have = 1; aw_n++; aw_wait = 0;
                end else if (o_awvalid) begin
                    aw_hold = 1; hold_awaddr = o_awaddr;
                end
                if (o_wvalid && i_wready) begin
                    slv_wdata = o_wdata; slv_wstrb = o_wstrb; w_have = 1; w_n++; w_wait = 0;
                end else if (o_wvalid) begin
                    w_hold = 1; hold_w = {o_wstrb, o_wdata};
                end
                if (o_arvalid && i_arready) begin
                    rd_addr = o_araddr; ar_n++; ar_wait = 0; r_arm = 1; r_tmr = rsp_dly;
                end else if (o_arvalid) begin
                    ar_hold = 1; hold_araddr = o_araddr;
                end
                if (i_bvalid && o_bready) begin b_n++; b_arm = 0; end
                if (i_rvalid && o_rready) begin r_n++; r_arm = 0; end
            end
            @(negedge clk);
            if (aw_hold) check_eq("aw_hold", 64'({o_awvalid, o_awaddr}), 64'({1'b1, hold_awaddr}));
            if (w_hold)  check_eq("w_hold", 64'({o_wvalid, o_wstrb, o_wdata}), 64'({1'b1, hold_w}));
            if (ar_hold) check_eq("ar_hold", 64'({o_arvalid, o_araddr}), 64'({1'b1, hold_araddr}));
            if (aw_have && w_have) begin
                if (slv_awaddr >= 64) begin
                    bresp_n = RESP_SLVERR;
                end else begin
                    bresp_n = RESP_OKAY;
                    m = '0;
                    for (int b = 0; b < SW; b++) if (slv_wstrb[b]) m[8*b +: 8] = 8'hFF;
                    if (slv_awaddr[5:2] != 4'd1)
                        slv_mem[slv_awaddr[5:2]] = (slv_mem[slv_awaddr[5:2]] & ~m) | (slv_wdata & m);
                end
                aw_have = 0; w_have = 0; b_arm = 1; b_tmr = rsp_dly;
            end
            i_bvalid = 0;
            if (b_arm) begin
                if (b_tmr == 0) i_bvalid = 1; else b_tmr--;
            end
            i_bresp = bresp_n;
            i_rvalid = 0;
            if (r_arm) begin
                if (r_tmr == 0) i_rvalid = 1; else r_tmr--;
            end
            i_rresp = (rd_addr >= 64) ? RESP_SLVERR : RESP_OKAY;
            i_rdata = (rd_addr >= 64) ? '0 : slv_mem[rd_addr[5:2]];
            i_awready = o_awvalid && !aw_have && (aw_wait >= aw_dly);
            if (o_awvalid && !i_awready) aw_wait++;
            i_wready = o_wvalid && !w_have && (w_wait >= w_dly);
            if (o_wvalid && !i_wready) w_wait++;
            i_arready = o_arvalid && (ar_wait >= ar_dly);
            if (o_arvalid && !i_arready) ar_wait++;
        end
    end

    // Reference memory: what the register map should return for each command
    task automatic ref_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb, output logic [1:0] resp,
                              output logic [DW-1:0] rdata);
        int idx;
        idx   = int'(addr[5:2]);
        rdata = '0;
        if (addr >= 64) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
            if (!wr) rdata = ref_mem[idx];
            else if (idx != 1)
                for (int b = 0; b < SW; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Issue one command from a negedge, collect and check its response, return at a negedge
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int hold, input bit chk_lat);
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_data;
        int            lat, aw0, w0, b0, ar0, r0;
        aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n;
        ref_access(wr, addr, data, strb, exp_resp, exp_data);
        i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
        check_eq("cmd_ready", 64'(o_cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 0;
        check_eq("req_valid", 64'({o_awvalid, o_wvalid, o_arvalid, o_busy}),
                 wr ? 64'(4'b1101) : 64'(4'b0011));
        check_eq("req_addr", 64'(wr ? o_awaddr : o_araddr), 64'(addr));
        if (wr) check_eq("req_wdata", 64'({o_wstrb, o_wdata}), 64'({strb, data}));
        @(negedge clk);
        lat = 2;
        if (wr) check_eq("wr_n2", 64'({o_awvalid, o_wvalid, o_bready}),
                         64'({aw_dly > 0, w_dly > 0, aw_dly == 0 && w_dly == 0}));
        else    check_eq("rd_n2", 64'({o_arvalid, o_rready}), 64'({ar_dly > 0, ar_dly == 0}));
        while (!o_rsp_valid && lat < 200) begin
            check_eq("busy_wait", 64'({o_cmd_ready, o_busy}), 64'(2'b01));
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_seen", 64'(o_rsp_valid), 64'd1);
        if (o_rsp_valid) begin
            if (chk_lat) check_eq("latency", 64'(lat), 64'd4);
            check_eq("rsp_resp", 64'(o_rsp_resp), 64'(exp_resp));
            check_eq("rsp_data", 64'(o_rsp_data), 64'(exp_data));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("rsp_hold", 64'({o_rsp_valid, o_cmd_ready, o_rsp_resp, o_rsp_data}),
                         64'({1'b1, 1'b0, exp_resp, exp_data}));
            end
            i_rsp_ready = 1;
            @(posedge clk);
            @(negedge clk);
            i_rsp_ready = 0;
            check_eq("rsp_release", 64'({o_rsp_valid, o_cmd_ready, o_busy}), 64'(3'b010));
            check_eq("hs_count", 64'({8'(aw_n - aw0), 8'(w_n - w0), 8'(b_n - b0),
                                      8'(ar_n - ar0), 8'(r_n - r0)}),
                     wr ? 64'(40'h01_01_01_00_00) : 64'(40'h00_00_00_01_01));
            if (wr) check_eq("slv_payload", 64'({slv_wstrb, slv_wdata}), 64'({strb, data}));
            if (wr) check_eq("slv_addr", 64'(slv_awaddr), 64'(addr));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : seq
        logic [1:0]    dr;
        logic [DW-1:0] dd;
        logic          seen;
        int            n;
        rst = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_data = '0;
        i_cmd_strb = '0; i_rsp_ready = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = (i == 1) ? VERSION : '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", 64'({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid,
                                  o_busy}), 64'd0);
        check_eq("rst_ready", 64'(o_cmd_ready), 64'd1);
        check_eq("rst_regs", 64'({o_awaddr, o_wdata}), 64'd0);
        check_eq("rst_rsp", 64'({o_wstrb, o_rsp_resp, o_rsp_data}), 64'd0);
        rst = 0;
        @(negedge clk);

        run_cmd(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
        check_eq("slv_reg0", 64'(slv_mem[0]), 64'hDEAD_BEEF);
        run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b1);
        aw_dly = 5;
        run_cmd(1'b1, 32'h8, 32'hCAFE_0123, 4'b0101, 0, 1'b0);
        aw_dly = 0;
        run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1);
        run_cmd(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b1);
        run_cmd(1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 10, 1'b1);

        // Reset while waiting for B: everything drops, no response follows
        rsp_dly = 8;
        i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = 32'h3C; i_cmd_data = 32'h1234_5678;
        i_cmd_strb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 0;
        n = 0;
        while (!o_bready && n < 20) begin @(negedge clk); n++; end
        check_eq("mid_wr_rsp", 64'(o_bready), 64'd1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_eq("mid_rst_ctrl", 64'({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                                      o_rsp_valid, o_busy, o_cmd_ready}), 64'd1);
        check_eq("mid_rst_regs", 64'({o_awaddr, o_wdata}), 64'd0);
        seen = 0;
        repeat (12) begin @(negedge clk); seen = seen | o_rsp_valid; end
        check_eq("mid_rst_no_rsp", 64'(seen), 64'd0);
        ref_access(1'b1, 32'h3C, 32'h1234_5678, 4'hF, dr, dd);
        rsp_dly = 1;
        run_cmd(1'b0, 32'h3C, 32'h0, 4'h0, 0, 1'b1);

        repeat (40) begin
            aw_dly  = int'($urandom_range(0, 3));
            w_dly   = int'($urandom_range(0, 3));
            ar_dly  = int'($urandom_range(0, 3));
            rsp_dly = int'($urandom_range(0, 3));
            run_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) << 2), 32'($urandom),
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Converts a simple one-at-a-time command interface into AXI4-Lite master transactions.
- Sits directly upstream of axi_lite_slave-based register blocks: it drives their AW/W/B/AR/R channels, typically from a test sequencer or an embedded controller.
- Allows exactly one outstanding transaction; results return on a response handshake.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- STROBE_WIDTH, DATA_WIDTH/8, byte-strobe width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_addr  in  ADDR_WIDTH  byte address
- i_cmd_data  in  DATA_WIDTH  write data
- i_cmd_strb  in  STROBE_WIDTH  write strobes
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed
- o_rsp_resp  out  2  AXI response code
- o_rsp_data  out  DATA_WIDTH  read data; 0 for writes
- o_busy  out  1  state != IDLE
- o_awvalid  out  1;  o_awaddr  out  ADDR_WIDTH;  i_awready  in  1
- o_wvalid  out  1;  o_wdata  out  DATA_WIDTH;  o_wstrb  out  STROBE_WIDTH;  i_wready  in  1
- i_bvalid  in  1;  i_bresp  in  2;  o_bready  out  1
- o_arvalid  out  1;  o_araddr  out  ADDR_WIDTH;  i_arready  in  1
- i_rvalid  in  1;  i_rresp  in  2;  i_rdata  in  DATA_WIDTH;  o_rready  out  1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all valid/ready outputs are 0. Address, data, response and rsp_data registers are 0. State is IDLE.
- Registered outputs: every output is registered except o_cmd_ready, which is (state==IDLE) and combinational from state only.
- Command capture: when i_cmd_valid && o_cmd_ready in cycle N, the block latches addr, data, strb and write.
  - Write: o_awvalid and o_wvalid both go high at N+1. State moves to WR_REQ.
  - Read: o_arvalid goes high at N+1. State moves to RD_REQ.
- WR_REQ:
  - AW and W complete independently. Each valid drops the cycle after its own handshake.
  - Same-cycle handshakes on both channels are legal.
  - When both have completed, move to WR_RSP with o_bready=1.
- WR_RSP: on i_bvalid, capture i_bresp, set o_rsp_data=0, drop o_bready, assert o_rsp_valid the next cycle. State moves to DONE.
- RD_REQ: on i_arready, drop o_arvalid. Move to RD_RSP with o_rready=1.
- RD_RSP: on i_rvalid, capture i_rdata and i_rresp, drop o_rready, assert o_rsp_valid the next cycle. State moves to DONE.
- DONE: hold o_rsp_valid and the response fields stable until i_rsp_ready, then return to IDLE. A new command can be accepted in the following cycle.
- AXI rules:
  - Valid never depends on ready.
  - Once valid is asserted, it and its payload are held until the handshake.
  - B/R beats arriving while not in WR_RSP/RD_RSP are ignored (protocol violation by the slave).
- Latency with always-ready slave and sink:
  - write: cmd accept to rsp_valid = 4 cycles.
  - read: cmd accept to rsp_valid = 4 cycles.
- Response codes pass through unmodified: SLVERR 2'b10 and DECERR 2'b11 are not treated as errors internally.
- Reset mid-operation: all valids drop at the next edge and no response is emitted. The outstanding slave transaction is abandoned; the slave must be reset alongside.

Optional Feature:
- Macro: AXI_LITE_CMD_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entering WR_REQ/RD_REQ and on every handshake, and increments in the other states.
  - When it reaches TIMEOUT_CYCLES-1, all AXI valids/readies drop. The block emits a response with o_rsp_resp=2'b11 and o_rsp_data=0, then enters DONE.
  - Late B/R beats after a timeout are ignored.
- Without the macro: no counter; the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds:
  - response localparams RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3;
  - state encodings IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE.
- No sub-module is needed; the FSM and optional watchdog fit in a single module.

Test Plan:
- Write 0x0000_0000 data 0xDEAD_BEEF strb 0xF to an always-ready slave -> AW/W handshake at N+1, o_rsp_valid at N+4 with resp 0, rsp_data 0, and slave register = 0xDEADBEEF.
- Read addr 0x4 from the version register -> o_rsp_data 0x1000_0000, resp 0, latency 4.
- Slave holds awready low 5 cycles while wready is immediate -> o_wvalid drops after 1 cycle, o_awvalid holds 5 cycles with stable addr, and exactly one B is accepted.
- Read invalid addr 0x40 against a slave returning SLVERR -> o_rsp_resp 2'b10, o_rsp_data 0.
- i_rsp_ready held low 10 cycles -> o_rsp_valid and data stable, o_cmd_ready=0 throughout; next command accepted the cycle after release.
- rst pulsed in WR_RSP -> outputs 0 next cycle, no rsp_valid. With TIMEOUT_EN, TIMEOUT_CYCLES=16 and bvalid never asserted -> rsp resp 2'b11 at cycle 16 of waiting.
